// File: rtl/gearbox_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : gearbox_seq_ctrl
//  Purpose  : Phase sequencer, back-pressure and alignment checker for the
//             66b-to-32b TX gearbox.
//  Revision : 1.0  initial release
// ============================================================================
module gearbox_seq_ctrl #(
    parameter int DATA_WIDTH    = 32,
    parameter int HDR_WIDTH     = 2,
    parameter int LOCK_FRAMES   = 2,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_enable,
    input  logic                     i_valid,
    input  logic                     i_sob,
    output logic                     o_ready,
    output logic [5:0]               o_seq,
    output logic                     o_hdr_sel,
    output logic                     o_gb_valid,
    output logic                     o_locked,
    output logic                     o_align_err,
    input  logic                     i_err_clr,
    output logic [ERR_CNT_WIDTH-1:0] o_err_cnt
);

    localparam logic [5:0] c_PAUSE = 6'(DATA_WIDTH);
    localparam logic [3:0] c_LOCK  = 4'(LOCK_FRAMES);

    // The 33-phase frame only closes for a 2-bit header on a 32-bit word.
    generate
        if (HDR_WIDTH != 2 || DATA_WIDTH != 32 || LOCK_FRAMES < 1 || LOCK_FRAMES > 15) begin : g_param_chk
            $error("gearbox_seq_ctrl: unsupported parameter set");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RESYNC = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [5:0]               seq_q, seq_d;
    logic [3:0]               lock_cnt_q, lock_cnt_d;
    logic                     locked_q, locked_d;
    logic                     align_err_q;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

    logic w_run;
    logic w_pause;
    logic w_ready;
    logic w_xfer;
    logic w_sob_ok;
    logic w_err;

    assign w_run    = (state_q == ST_RUN);
    assign w_pause  = w_run && (seq_q == c_PAUSE);
    assign w_ready  = (state_q == ST_RESYNC) || (w_run && !w_pause);
    assign w_xfer   = i_valid && w_ready;
    assign w_sob_ok = (i_sob == ~seq_q[0]);

    assign o_ready     = w_ready;
    assign o_seq       = w_run ? seq_q : 6'd0;
    assign o_hdr_sel   = (state_q != ST_IDLE) && !o_seq[0] && (o_seq < c_PAUSE);
    assign o_locked    = locked_q;
    assign o_align_err = align_err_q;
    assign o_err_cnt   = err_cnt_q;

    always_comb begin
        o_gb_valid = 1'b0;
        case (state_q)
            ST_RESYNC: o_gb_valid = w_xfer && i_sob;
            ST_RUN:    o_gb_valid = w_pause || (w_xfer && w_sob_ok);
            default:   o_gb_valid = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        seq_d      = seq_q;
        lock_cnt_d = lock_cnt_q;
        locked_d   = (lock_cnt_q == c_LOCK);
        w_err      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_enable) state_d = ST_RESYNC;
            end
            ST_RESYNC: begin
                if (w_xfer && i_sob) begin
                    state_d = ST_RUN;
                    seq_d   = 6'd1;
                end
            end
            ST_RUN: begin
                if (w_pause) begin
                    seq_d = 6'd0;
                    if (lock_cnt_q != c_LOCK) lock_cnt_d = lock_cnt_q + 4'd1;
                end else if (w_xfer && w_sob_ok) begin
                    seq_d = seq_q + 6'd1;
                end else begin
                    w_err      = 1'b1;
                    state_d    = ST_RESYNC;
                    seq_d      = 6'd0;
                    lock_cnt_d = 4'd0;
                    locked_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                seq_d   = 6'd0;
            end
        endcase

        // Disable overrides everything, including an error in the same cycle.
        if (!i_enable) begin
            state_d    = ST_IDLE;
            seq_d      = 6'd0;
            lock_cnt_d = 4'd0;
            locked_d   = 1'b0;
            w_err      = 1'b0;
        end
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (i_err_clr) begin
            err_cnt_d = '0;
        end else if (w_err && (err_cnt_q != {ERR_CNT_WIDTH{1'b1}})) begin
            err_cnt_d = err_cnt_q + {{(ERR_CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            seq_q       <= 6'd0;
            lock_cnt_q  <= 4'd0;
            locked_q    <= 1'b0;
            align_err_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            seq_q       <= seq_d;
            lock_cnt_q  <= lock_cnt_d;
            locked_q    <= locked_d;
            align_err_q <= w_err;
            err_cnt_q   <= err_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gearbox_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gearbox_seq_ctrl
//  Purpose  : Directed self-checking bench for gearbox_seq_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gearbox_seq_ctrl;

    // Narrow error counter keeps the saturation sequence short.
    localparam int ERRW = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            enable;
    logic            valid;
    logic            sob;
    logic            err_clr;
    logic            ready;
    logic [5:0]      seq;
    logic            hdr;
    logic            gbv;
    logic            locked;
    logic            align_err;
    logic [ERRW-1:0] err_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    gearbox_seq_ctrl #(
        .DATA_WIDTH    (32),
        .HDR_WIDTH     (2),
        .LOCK_FRAMES   (2),
        .ERR_CNT_WIDTH (ERRW)
    ) u_dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_enable    (enable),
        .i_valid     (valid),
        .i_sob       (sob),
        .o_ready     (ready),
        .o_seq       (seq),
        .o_hdr_sel   (hdr),
        .o_gb_valid  (gbv),
        .o_locked    (locked),
        .o_align_err (align_err),
        .i_err_clr   (err_clr),
        .o_err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Feed a correctly aligned stream for phases first..last of a frame.
    task automatic run_seq(input int first, input int last);
        for (int s = first; s <= last; s++) begin
            logic [5:0] sv;
            sv    = 6'(s);
            valid = 1'b1;
            sob   = (s < 32) ? ~sv[0] : 1'b1;
            #1;
            check_eq("seq",   32'(seq), 32'(sv));
            check_eq("ready", 32'(ready), 32'(s != 32));
            check_eq("gbv",   32'(gbv), 32'd1);
            check_eq("hdr",   32'(hdr), 32'((s < 32) && !sv[0]));
            tick();
        end
    endtask

    // From RESYNC: accept a start word, then starve phase 1.
    task automatic make_err();
        valid = 1'b1; sob = 1'b1;
        tick();
        valid = 1'b0;
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ready"},  32'(ready), 32'd0);
        check_eq({tag, "_seq"},    32'(seq), 32'd0);
        check_eq({tag, "_hdr"},    32'(hdr), 32'd0);
        check_eq({tag, "_gbv"},    32'(gbv), 32'd0);
        check_eq({tag, "_locked"}, 32'(locked), 32'd0);
        check_eq({tag, "_aerr"},   32'(align_err), 32'd0);
        check_eq({tag, "_cnt"},    32'(err_cnt), 32'd0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; enable = 1'b0; valid = 1'b0; sob = 1'b0; err_clr = 1'b0;
        tick(); tick();
        check_all_zero("reset");

        // Test 1: bring-up and lock
        reset = 1'b0; enable = 1'b1; valid = 1'b1; sob = 1'b1;
        #1;
        check_eq("idle_ready", 32'(ready), 32'd0);
        check_eq("idle_hdr",   32'(hdr), 32'd0);
        tick();
        #1;
        check_eq("resync_ready", 32'(ready), 32'd1);
        check_eq("resync_gbv",   32'(gbv), 32'd1);
        tick();
        run_seq(1, 32);
        run_seq(0, 32);
        valid = 1'b1; sob = 1'b1; #1;
        check_eq("lock_pre", 32'(locked), 32'd0);
        run_seq(0, 0);
        valid = 1'b1; sob = 1'b0; #1;
        check_eq("lock_post", 32'(locked), 32'd1);
        check_eq("cnt_t1",    32'(err_cnt), 32'd0);

        // Test 2: header mismatch at seq 9
        run_seq(1, 8);
        valid = 1'b1; sob = 1'b1; #1;
        check_eq("t2_gbv", 32'(gbv), 32'd0);
        tick();
        valid = 1'b1; sob = 1'b0; #1;
        check_eq("t2_aerr",   32'(align_err), 32'd1);
        check_eq("t2_cnt",    32'(err_cnt), 32'd1);
        check_eq("t2_locked", 32'(locked), 32'd0);
        check_eq("t2_seq",    32'(seq), 32'd0);
        check_eq("t2_ready",  32'(ready), 32'd1);
        check_eq("t2_disc1",  32'(gbv), 32'd0);
        tick();
        #1;
        check_eq("t2_aerr_pulse", 32'(align_err), 32'd0);
        check_eq("t2_disc2",      32'(gbv), 32'd0);
        tick();
        sob = 1'b1; #1;
        check_eq("t2_cnt_hold", 32'(err_cnt), 32'd1);
        check_eq("t2_restart",  32'(gbv), 32'd1);
        tick();
        check_eq("t2_seq1", 32'(seq), 32'd1);

        // Test 3: underflow at seq 15, idle at the pause is fine
        run_seq(1, 14);
        valid = 1'b0; #1;
        check_eq("t3_gbv", 32'(gbv), 32'd0);
        tick();
        check_eq("t3_aerr", 32'(align_err), 32'd1);
        check_eq("t3_cnt",  32'(err_cnt), 32'd2);
        check_eq("t3_seq",  32'(seq), 32'd0);
        valid = 1'b1; sob = 1'b1;
        tick();
        run_seq(1, 31);
        valid = 1'b0; #1;
        check_eq("t3_pause_ready", 32'(ready), 32'd0);
        check_eq("t3_pause_gbv",   32'(gbv), 32'd1);
        tick();
        valid = 1'b1; sob = 1'b1; #1;
        check_eq("t3_wrap_seq", 32'(seq), 32'd0);
        check_eq("t3_no_aerr",  32'(align_err), 32'd0);
        check_eq("t3_cnt_hold", 32'(err_cnt), 32'd2);
        run_seq(0, 19);

        // Test 4: disable coincident with a mismatch at seq 20
        enable = 1'b0; valid = 1'b1; sob = 1'b0;
        tick();
        check_eq("t4_ready", 32'(ready), 32'd0);
        check_eq("t4_seq",   32'(seq), 32'd0);
        check_eq("t4_aerr",  32'(align_err), 32'd0);
        check_eq("t4_cnt",   32'(err_cnt), 32'd2);

        // Test 5: saturation and clear priority
        enable = 1'b1; valid = 1'b0;
        tick();
        for (int i = 0; i < 253; i++) make_err();
        check_eq("t5_sat", 32'(err_cnt), 32'd255);
        make_err();
        check_eq("t5_sat_hold", 32'(err_cnt), 32'd255);
        check_eq("t5_sat_aerr", 32'(align_err), 32'd1);
        valid = 1'b1; sob = 1'b1;
        tick();
        valid = 1'b0; err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_eq("t5_clr",      32'(err_cnt), 32'd0);
        check_eq("t5_clr_aerr", 32'(align_err), 32'd1);
        make_err();
        check_eq("t5_after_clr", 32'(err_cnt), 32'd1);

        // Test 6: asynchronous reset at seq 27 of a locked frame
        valid = 1'b1; sob = 1'b1;
        tick();
        run_seq(1, 32);
        run_seq(0, 32);
        run_seq(0, 26);
        valid = 1'b1; sob = 1'b0; #1;
        check_eq("t6_pre_seq",    32'(seq), 32'd27);
        check_eq("t6_pre_locked", 32'(locked), 32'd1);
        reset = 1'b1; #1;
        check_all_zero("t6_async");
        tick(); tick();
        reset = 1'b0; valid = 1'b1; sob = 1'b1; #1;
        check_eq("t6_idle_ready", 32'(ready), 32'd0);
        tick();
        #1;
        check_eq("t6_resync_ready", 32'(ready), 32'd1);
        check_eq("t6_resync_gbv",   32'(gbv), 32'd1);
        tick();
        run_seq(1, 32);
        valid = 1'b1; sob = 1'b1; #1;
        check_eq("t6_lock_f1", 32'(locked), 32'd0);
        run_seq(0, 32);
        valid = 1'b1; sob = 1'b1; #1;
        check_eq("t6_lock_f2", 32'(locked), 32'd0);
        run_seq(0, 0);
        valid = 1'b1; sob = 1'b0; #1;
        check_eq("t6_lock", 32'(locked), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
